// File: rtl/result_collector_pkg.sv
// result_collector_pkg: shared FSM states, tag-to-entry maps and stream order tables for result_collector
package result_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_STREAM  = 2'd2
    } state_t;

    localparam logic [2:0] NO_CAPTURE  = 3'b111;
    localparam int         NUM_ENTRIES = 10;

    // Buffer entries are numbered in upper-triangle row-major order:
    // 0=b11 1=b12 2=b13 3=b14 4=b22 5=b23 6=b24 7=b33 8=b34 9=b44
    localparam logic [3:0] MAC1_ENTRY [0:7] = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd0, 4'd0, 4'd0};
    localparam logic [3:0] MAC2_ENTRY [0:7] = '{4'd0, 4'd4, 4'd7, 4'd9, 4'd6, 4'd0, 4'd0, 4'd0};

    // Upper-triangle stream: word n reads entry n and reports this element index
    localparam logic [3:0] UT_IDX [0:9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd10, 4'd11, 4'd15};

    // Full-matrix stream: word n is element n; lower elements mirror the upper entry
    localparam logic [3:0] FULL_ENTRY [0:15] = '{4'd0, 4'd1, 4'd2, 4'd3,
                                                 4'd1, 4'd4, 4'd5, 4'd6,
                                                 4'd2, 4'd5, 4'd7, 4'd8,
                                                 4'd3, 4'd6, 4'd8, 4'd9};

    function automatic logic tag_legal(input logic [2:0] t);
        return t < 3'd5;
    endfunction

    function automatic logic tag_illegal(input logic [2:0] t);
        return (t == 3'd5) || (t == 3'd6);
    endfunction

endpackage

// File: rtl/result_buffer.sv
// result_buffer: 10-entry dual-write register file with captured mask and one read port
module result_buffer
    import result_collector_pkg::*;
#(
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             we1,
    input  logic [3:0]       wa1,
    input  logic [ACC_W-1:0] wd1,
    input  logic             we2,
    input  logic [3:0]       wa2,
    input  logic [ACC_W-1:0] wd2,
    input  logic [3:0]       ra,
    output logic [ACC_W-1:0] rd,
    output logic             dup,
    output logic             complete
);

    logic [ACC_W-1:0]       mem [0:NUM_ENTRIES-1];
    logic [NUM_ENTRIES-1:0] mask;
    logic [NUM_ENTRIES-1:0] set_bits;

    // Bits newly captured this cycle; the two tag maps never share an entry
    always_comb begin
        set_bits = (we1 ? (10'd1 << wa1) : 10'd0) | (we2 ? (10'd1 << wa2) : 10'd0);
    end

    assign dup      = |(set_bits & mask);
    assign complete = &(mask | set_bits);
    assign rd       = mem[ra];

    // Data storage is not reset; the mask alone says what is valid
    always_ff @(posedge clk) begin
        if (we1) mem[wa1] <= wd1;
        if (we2) mem[wa2] <= wd2;
    end

    // Captured mask: cleared on reset or a new coefficient set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     mask <= '0;
        else if (clear) mask <= '0;
        else            mask <= mask | set_bits;
    end

endmodule

// File: rtl/result_collector.sv
// result_collector: gathers MAC results into a symmetric 4x4 matrix and streams it out
// Define RESULT_COLLECTOR_FULL_MATRIX_EN to stream all 16 elements instead of the upper triangle.
module result_collector
    import result_collector_pkg::*;
#(
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cf_load,
    input  logic [ACC_W-1:0] mac1_out,
    input  logic [ACC_W-1:0] mac2_out,
    input  logic [2:0]       mac1_output_sel,
    input  logic [2:0]       mac2_output_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [3:0]       out_idx,
    output logic             out_last,
    output logic             done,
    output logic             tag_err
);

    state_t           state;
    logic [3:0]       ptr;
    logic [3:0]       ra;
    logic [3:0]       idx;
    logic [ACC_W-1:0] rd;
    logic             collecting;
    logic             we1;
    logic             we2;
    logic             dup;
    logic             complete;
    logic             is_last;

`ifdef RESULT_COLLECTOR_FULL_MATRIX_EN
    localparam logic [3:0] LAST_PTR = 4'd15;
    assign ra  = FULL_ENTRY[ptr];
    assign idx = ptr;
`else
    localparam logic [3:0] LAST_PTR = 4'd9;
    assign ra  = ptr;
    assign idx = UT_IDX[ptr];
`endif

    // cf_load outranks any capture in the same cycle
    assign collecting = (state == ST_COLLECT) && !cf_load;
    assign we1        = collecting && tag_legal(mac1_output_sel);
    assign we2        = collecting && tag_legal(mac2_output_sel);
    assign is_last    = ptr == LAST_PTR;
    assign out_valid  = state == ST_STREAM;
    assign out_data   = out_valid ? rd : '0;
    assign out_idx    = out_valid ? idx : 4'd0;
    assign out_last   = out_valid && is_last;

    result_buffer #(.ACC_W(ACC_W)) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cf_load),
        .we1      (we1),
        .wa1      (MAC1_ENTRY[mac1_output_sel]),
        .wd1      (mac1_out),
        .we2      (we2),
        .wa2      (MAC2_ENTRY[mac2_output_sel]),
        .wd2      (mac2_out),
        .ra       (ra),
        .rd       (rd),
        .dup      (dup),
        .complete (complete)
    );

    // Collect until the mask fills, then stream with ready/valid handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ptr     <= 4'd0;
            done    <= 1'b0;
            tag_err <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cf_load) begin
                state   <= ST_COLLECT;
                ptr     <= 4'd0;
                tag_err <= 1'b0;
            end else if (state == ST_COLLECT) begin
                if (dup || tag_illegal(mac1_output_sel) || tag_illegal(mac2_output_sel))
                    tag_err <= 1'b1;
                if (complete) begin
                    state <= ST_STREAM;
                    ptr   <= 4'd0;
                end
            end else if (state == ST_STREAM && out_ready) begin
                if (is_last) begin
                    state <= ST_IDLE;
                    done  <= 1'b1;
                end else begin
                    ptr <= ptr + 4'd1;
                end
            end
        end
    end

endmodule
